// File: rtl/tx_buf_ctrl_pkg.sv
// Shared definitions for the UART transmit byte-buffer sequencer:
// read-FSM encoding, default geometry and BRAM read latency.
package tx_buf_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    SEND  = 2'd2,
    HOLD  = 2'd3
  } rd_state_e;

  localparam int unsigned DEFAULT_DEPTH   = 200000;
  localparam int unsigned DEFAULT_AW      = 20;
  localparam int unsigned BRAM_RD_LATENCY = 1;

endpackage

// File: rtl/tx_buf_ctrl.sv
// Circular-FIFO sequencer for the UART TX byte buffer: writes core bytes into
// an external simple dual-port BRAM and drains them under a ready/start handshake.
module tx_buf_ctrl
  import tx_buf_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned AW    = DEFAULT_AW
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          in_valid_i,
  input  logic [7:0]    in_data_i,
  output logic          in_ready_o,
  input  logic          tx_ready_i,
  output logic          tx_start_o,
  output logic [7:0]    tx_data_o,
  output logic          ena_o,
  output logic          wea_o,
  output logic [AW-1:0] addra_o,
  output logic [7:0]    dia_o,
  output logic          enb_o,
  output logic [AW-1:0] addrb_o,
  input  logic [7:0]    dob_i,
  output logic [AW-1:0] count_o,
  output logic          empty_o
);

  localparam logic [AW-1:0] LAST_SLOT = AW'(DEPTH - 1);
  localparam logic [AW-1:0] FULL_CNT  = AW'(DEPTH);

  rd_state_e     state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] count_q, count_d;
  logic [7:0]    tx_data_q, tx_data_d;

  logic in_ready;
  logic wr_accept;
  logic send_fire;

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + 1'b1;
  endfunction

  // Full is judged on the registered count, so a slot freed by SEND opens next cycle.
  assign in_ready  = (count_q != FULL_CNT);
  assign wr_accept = in_valid_i && in_ready;
  assign send_fire = (state_q == SEND) && tx_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      tx_data_q <= tx_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_accept ? ptr_next(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d  = send_fire ? ptr_next(rd_ptr_q) : rd_ptr_q;
    tx_data_d = (state_q == LATCH) ? dob_i : tx_data_q;
    count_d   = count_q;
    case ({wr_accept, send_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // HOLD gives the UART one cycle to drop tx_ready before the next byte.
    case (state_q)
      IDLE:    if (count_q != '0) state_d = LATCH;
      LATCH:   state_d = SEND;
      SEND:    if (tx_ready_i) state_d = HOLD;
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready_o = in_ready;
    ena_o      = wr_accept;
    wea_o      = wr_accept;
    addra_o    = wr_ptr_q;
    dia_o      = in_data_i;
    enb_o      = (state_q == IDLE) && (count_q != '0);
    addrb_o    = rd_ptr_q;
    tx_start_o = send_fire;
    tx_data_o  = tx_data_q;
    count_o    = count_q;
    empty_o    = (count_q == '0);
  end

endmodule
